stack_word_seq: RTL and testbench

//  Word-level front end for the byte-wide stack pointer/stack unit.
//  - Converts 16-bit PUSH/POP requests from the control unit (PUSH rp, POP rp, CALL, RET)

---
 rtl/stack_word_seq.sv | 136 +++++++++++++
 tb/tb_stack_word_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_word_seq.sv
// Word-level sequencer in front of a byte-wide stack unit: splits 16-bit pushes and pops
// into two byte transactions, reassembles popped words and refuses overflow/underflow.
module stack_word_seq #(
  parameter logic [15:0] SP_LOW_LIMIT  = 16'h0002,
  parameter logic [15:0] SP_HIGH_LIMIT = 16'hFFFD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_push,
  input  logic        req_pop,
  input  logic [15:0] word_in,
  output logic [15:0] word_out,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        stk_enable,
  output logic        stk_decrement,
  output logic        stk_increment,
  output logic [7:0]  stk_data_in,
  input  logic [7:0]  stk_data_out,
  input  logic [15:0] stk_sp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH_HI,
    S_PUSH_LO,
    S_POP_LO,
    S_POP_HI,
    S_POP_CAP,
    S_DONE,
    S_FAIL
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic [15:0] word_out_q, word_out_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        stk_enable_q, stk_enable_d;
  logic        stk_decrement_q, stk_decrement_d;
  logic        stk_increment_q, stk_increment_d;
  logic [7:0]  stk_data_in_q, stk_data_in_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    word_d     = word_q;
    word_out_d = word_out_q;

    case (state_q)
      S_IDLE: begin
        if (req_push && req_pop) begin
          state_d = S_FAIL;
        end else if (req_push) begin
          if (stk_sp < SP_LOW_LIMIT) begin
            state_d = S_FAIL;
          end else begin
            word_d  = word_in;
            state_d = S_PUSH_HI;
          end
        end else if (req_pop) begin
          state_d = (stk_sp > SP_HIGH_LIMIT) ? S_FAIL : S_POP_LO;
        end
      end
      S_PUSH_HI: state_d = S_PUSH_LO;
      S_PUSH_LO: state_d = S_DONE;
      S_POP_LO:  state_d = S_POP_HI;
      S_POP_HI: begin
        // Byte from the POP_LO increment is on stk_data_out now: it is the low byte.
        word_d[7:0] = stk_data_out;
        state_d     = S_POP_CAP;
      end
      S_POP_CAP: begin
        word_d[15:8] = stk_data_out;
        word_out_d   = {stk_data_out, word_q[7:0]};
        state_d      = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered copies of the next-state decode, so they line up with state_q
  // and never carry a combinational path from the request inputs.
  always_comb begin
    busy_d          = (state_d != S_IDLE);
    done_d          = (state_d == S_DONE) || (state_d == S_FAIL);
    err_d           = (state_d == S_FAIL);
    stk_decrement_d = (state_d == S_PUSH_HI) || (state_d == S_PUSH_LO);
    stk_increment_d = (state_d == S_POP_LO) || (state_d == S_POP_HI);
    stk_enable_d    = stk_decrement_d || stk_increment_d;
    stk_data_in_d   = 8'h00;
    if (state_d == S_PUSH_HI) stk_data_in_d = word_d[15:8];
    if (state_d == S_PUSH_LO) stk_data_in_d = word_d[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      word_q          <= 16'h0000;
      word_out_q      <= 16'h0000;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      stk_enable_q    <= 1'b0;
      stk_decrement_q <= 1'b0;
      stk_increment_q <= 1'b0;
      stk_data_in_q   <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values.
      state_q         <= state_d;
      word_q          <= word_d;
      word_out_q      <= word_out_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      err_q           <= err_d;
      stk_enable_q    <= stk_enable_d;
      stk_decrement_q <= stk_decrement_d;
      stk_increment_q <= stk_increment_d;
      stk_data_in_q   <= stk_data_in_d;
    end
  end

  assign word_out      = word_out_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign stk_enable    = stk_enable_q;
  assign stk_decrement = stk_decrement_q;
  assign stk_increment = stk_increment_q;
  assign stk_data_in   = stk_data_in_q;

endmodule

// File: tb/tb_stack_word_seq.sv
// Directed bench for stack_word_seq with a small byte-stack model (pre-decrement push,
// post-increment pop, registered read data).
module tb_stack_word_seq;

  logic        clk;
  logic        reset;
  logic        req_push;
  logic        req_pop;
  logic [15:0] word_in;
  logic [15:0] word_out;
  logic        busy;
  logic        done;
  logic        err;
  logic        stk_enable;
  logic        stk_decrement;
  logic        stk_increment;
  logic [7:0]  stk_data_in;
  logic [7:0]  stk_data_out;
  logic [15:0] stk_sp;

  stack_word_seq dut (
    .clk          (clk),
    .reset        (reset),
    .req_push     (req_push),
    .req_pop      (req_pop),
    .word_in      (word_in),
    .word_out     (word_out),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .stk_enable   (stk_enable),
    .stk_decrement(stk_decrement),
    .stk_increment(stk_increment),
    .stk_data_in  (stk_data_in),
    .stk_data_out (stk_data_out),
    .stk_sp       (stk_sp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte stack model.
  logic [7:0]  mem [0:65535];
  logic [15:0] sp;
  logic [7:0]  dout;
  logic        load_en;
  logic [15:0] load_val;

  always @(posedge clk) begin
    if (load_en) begin
      sp <= load_val;
    end else if (stk_enable && stk_decrement) begin
      sp               <= sp - 16'd1;
      mem[sp - 16'd1]  <= stk_data_in;
    end else if (stk_enable && stk_increment) begin
      dout <= mem[sp];
      sp   <= sp + 16'd1;
    end
  end

  assign stk_sp       = sp;
  assign stk_data_out = dout;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-operation observations.
  int          n_dec, n_inc, n_en, n_done, n_busy, done_cyc;
  logic        err_at_done;
  logic [15:0] word_at_done;
  logic [7:0]  b_first, b_second;

  task automatic set_sp(input logic [15:0] v);
    @(negedge clk);
    load_en  = 1'b1;
    load_val = v;
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  // Issue one request and observe 8 cycles; cycle 1 is the state after the sampling edge.
  task automatic run_op(input logic push, input logic pop, input logic [15:0] w,
                        input int inject_pop_at);
    n_dec = 0; n_inc = 0; n_en = 0; n_done = 0; n_busy = 0; done_cyc = 0;
    err_at_done = 1'b0; word_at_done = 16'h0; b_first = 8'h0; b_second = 8'h0;
    @(negedge clk);
    req_push = push;
    req_pop  = pop;
    word_in  = w;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      req_push = 1'b0;
      req_pop  = (c == inject_pop_at);
      if (stk_enable) n_en++;
      if (busy) n_busy++;
      if (stk_enable && stk_decrement) begin
        if (n_dec == 0) b_first = stk_data_in;
        else            b_second = stk_data_in;
        n_dec++;
      end
      if (stk_enable && stk_increment) n_inc++;
      if (done) begin
        n_done++;
        if (done_cyc == 0) begin
          done_cyc     = c;
          err_at_done  = err;
          word_at_done = word_out;
        end
      end
    end
    req_pop = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    req_push = 1'b0;
    req_pop  = 1'b0;
    word_in  = 16'h0;
    load_en  = 1'b0;
    load_val = 16'h0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_enable", stk_enable, 0);
    check("rst_data_in", stk_data_in, 8'h00);
    check("rst_word_out", word_out, 16'h0000);
    reset = 1'b0;

    // Push ABCD.
    set_sp(16'h1000);
    run_op(1'b1, 1'b0, 16'hABCD, 0);
    check("push_ndec", n_dec, 2);
    check("push_ninc", n_inc, 0);
    check("push_byte_hi", b_first, 8'hAB);
    check("push_byte_lo", b_second, 8'hCD);
    check("push_done_cyc", done_cyc, 3);
    check("push_err", err_at_done, 0);
    check("push_busy_cyc", n_busy, 3);

    // Pop it back: model returns CD then AB.
    run_op(1'b0, 1'b1, 16'h0000, 0);
    check("pop_ninc", n_inc, 2);
    check("pop_ndec", n_dec, 0);
    check("pop_done_cyc", done_cyc, 4);
    check("pop_word", word_at_done, 16'hABCD);
    check("pop_err", err_at_done, 0);
    check("pop_busy_cyc", n_busy, 4);

    // Refused push and pop.
    set_sp(16'h0001);
    run_op(1'b1, 1'b0, 16'h1111, 0);
    check("ovf_done_cyc", done_cyc, 1);
    check("ovf_err", err_at_done, 1);
    check("ovf_enable", n_en, 0);
    set_sp(16'hFFFE);
    run_op(1'b0, 1'b1, 16'h0000, 0);
    check("unf_done_cyc", done_cyc, 1);
    check("unf_err", err_at_done, 1);
    check("unf_enable", n_en, 0);
    check("unf_word_kept", word_out, 16'hABCD);

    // Boundaries: push from FFFF leaves SP at FFFD, pop at FFFD is accepted.
    set_sp(16'hFFFF);
    run_op(1'b1, 1'b0, 16'h1234, 0);
    check("bnd_push_done", done_cyc, 3);
    check("bnd_push_err", err_at_done, 0);
    run_op(1'b0, 1'b1, 16'h0000, 0);
    check("bnd_pop_done", done_cyc, 4);
    check("bnd_pop_word", word_at_done, 16'h1234);
    set_sp(16'h0002);
    run_op(1'b1, 1'b0, 16'h5678, 0);
    check("bnd_low_done", done_cyc, 3);
    check("bnd_low_ndec", n_dec, 2);

    // Simultaneous requests.
    set_sp(16'h8000);
    run_op(1'b1, 1'b1, 16'h9999, 0);
    check("both_done_cyc", done_cyc, 1);
    check("both_err", err_at_done, 1);
    check("both_enable", n_en, 0);
    check("both_word_kept", word_out, 16'h1234);

    // Pop request during PUSH_LO is ignored.
    set_sp(16'h1000);
    run_op(1'b1, 1'b0, 16'hBEEF, 2);
    check("ign_ndec", n_dec, 2);
    check("ign_ninc", n_inc, 0);
    check("ign_ndone", n_done, 1);

    // Reset asserted in the middle of PUSH_LO.
    set_sp(16'h1000);
    @(negedge clk);
    req_push = 1'b1;
    word_in  = 16'h0F0F;
    @(negedge clk);
    req_push = 1'b0;
    @(negedge clk);
    check("mid_pre_dec", stk_decrement, 1);
    reset = 1'b1;
    #1;
    check("mid_enable", stk_enable, 0);
    check("mid_dec", stk_decrement, 0);
    check("mid_busy", busy, 0);
    check("mid_word_out", word_out, 16'h0000);
    #1;
    reset = 1'b0;
    set_sp(16'h1000);
    run_op(1'b1, 1'b0, 16'h0F0F, 0);
    check("post_ndec", n_dec, 2);
    check("post_byte_lo", b_second, 8'h0F);
    check("post_done_cyc", done_cyc, 3);
    check("post_err", err_at_done, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
